// File: rtl/pipeline_piso.sv
// -----------------------------------------------------------------------------
// pipeline_piso
//   Parallel-in, serial-out word shift register. Takes a snapshot of NUM_WORDS
//   words over a valid/ready handshake, then replays it one word per enabled
//   cycle. The highest index goes first, so a snapshot taken from a
//   serial-in/parallel-out delay line comes back out in its original order.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   load_valid  snapshot on `in` is valid
//   load_ready  block can accept a snapshot this cycle (combinational)
//   in          parallel snapshot; in[NUM_WORDS-1] is emitted first
//   shift_en    consume the current `out` word and advance
//   out         current serial word (registered)
//   out_valid   `out` holds a frame word (registered)
//   out_last    `out` holds the final word of the frame (registered)
//   done        one-cycle pulse after the final word is consumed (registered)
// -----------------------------------------------------------------------------
module pipeline_piso #(
    parameter int unsigned           DATA_WIDTH = 1,
    parameter int unsigned           NUM_WORDS  = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_valid,
    output logic                                 load_ready,
    input  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] in,
    input  logic                                 shift_en,
    output logic [DATA_WIDTH-1:0]                out,
    output logic                                 out_valid,
    output logic                                 out_last,
    output logic                                 done
);

    generate
        if (NUM_WORDS < 2) begin : g_bad_num_words
            $error("pipeline_piso: NUM_WORDS must be >= 2");
        end
    endgenerate

    localparam int unsigned     CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                                state_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  words_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic [DATA_WIDTH-1:0]                 out_q;
    logic                                  out_valid_q;
    logic                                  out_last_q;
    logic                                  done_q;

    logic                                  load_fire;
    logic                                  last_shift;

    // The last shift of a frame frees the register on the same edge, which is
    // what lets back-to-back frames run with no bubble.
    assign last_shift = (state_q == S_SHIFT) && out_last_q && shift_en;
    assign load_ready = !reset && ((state_q == S_IDLE) || last_shift);
    assign load_fire  = load_ready && load_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            words_q     <= {NUM_WORDS{IDLE_VALUE}};
            cnt_q       <= '0;
            out_q       <= IDLE_VALUE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= last_shift;
            if (load_fire) begin
                // First word goes straight to the output register so it is
                // visible the cycle after the handshake.
                state_q     <= S_SHIFT;
                words_q     <= in;
                cnt_q       <= '0;
                out_q       <= in[NUM_WORDS-1];
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
            end else if (last_shift) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                out_q       <= IDLE_VALUE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if ((state_q == S_SHIFT) && shift_en) begin
                // Rotate so the next word to emit always sits in the top slot
                // after the move; the word just emitted wraps to the bottom.
                words_q     <= {words_q[NUM_WORDS-2:0], words_q[NUM_WORDS-1]};
                out_q       <= words_q[NUM_WORDS-2];
                cnt_q       <= cnt_q + CNT_W'(1);
                out_last_q  <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pipeline_piso.sv
module tb_pipeline_piso;

    localparam int unsigned    DW    = 8;
    localparam int unsigned    NW    = 4;
    localparam logic [DW-1:0]  IDLEV = 8'hE5;

    logic                      clk;
    logic                      reset;
    logic                      load_valid;
    logic                      load_ready;
    logic [NW-1:0][DW-1:0]     in_w;
    logic                      shift_en;
    logic [DW-1:0]             out_w;
    logic                      out_valid;
    logic                      out_last;
    logic                      done;

    int n_cmp;
    int n_fail;

    pipeline_piso #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .IDLE_VALUE (IDLEV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in         (in_w),
        .shift_en   (shift_en),
        .out        (out_w),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic        se;
        logic [31:0] din;
        logic        exp_lr;
        logic [7:0]  exp_out;
        logic        exp_ov;
        logic        exp_ol;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic lv, input logic se, input logic [31:0] din,
                                input logic lr, input logic [7:0] o, input logic ov,
                                input logic ol, input logic dn);
        vec_t v;
        v.lv = lv; v.se = se; v.din = din; v.exp_lr = lr;
        v.exp_out = o; v.exp_ov = ov; v.exp_ol = ol; v.exp_done = dn;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs applied #1 after a rising edge; load_ready checked before the
    // next edge, registered outputs checked #1 after it.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        load_valid = v.lv;
        shift_en   = v.se;
        in_w       = v.din;
        #1;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(v.exp_lr));
        @(posedge clk); #1;
        chk({tag, ".out"},       32'(out_w),     32'(v.exp_out));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        chk({tag, ".out_last"},  32'(out_last),  32'(v.exp_ol));
        chk({tag, ".done"},      32'(done),      32'(v.exp_done));
    endtask

    task automatic cyc(input logic lv, input logic se, input logic [31:0] din);
        load_valid = lv;
        shift_en   = se;
        in_w       = din;
        @(posedge clk); #1;
    endtask

    logic [NW-1:0][DW-1:0] sipo;
    logic [DW-1:0]         stream [NW];

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        load_valid = 1'b0;
        shift_en = 1'b0;
        in_w = '0;

        // Reset state
        #3;
        chk("rst.out",        32'(out_w),      32'(IDLEV));
        chk("rst.out_valid",  32'(out_valid),  0);
        chk("rst.out_last",   32'(out_last),   0);
        chk("rst.done",       32'(done),       0);
        chk("rst.load_ready", 32'(load_ready), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // --- idle with shift_en toggling
        add(0, 1, 32'h0, 1, IDLEV, 0, 0, 0);
        add(0, 0, 32'h0, 1, IDLEV, 0, 0, 0);
        // --- continuous shift
        add(1, 0, 32'h44332211, 1, 8'h44, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h33, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h22, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h11, 1, 1, 0);
        add(0, 1, 32'h0,        1, IDLEV, 0, 0, 1);
        add(0, 0, 32'h0,        1, IDLEV, 0, 0, 0);
        // --- shift every third cycle; a load attempt mid-frame is ignored
        add(1, 0, 32'h44332211, 1, 8'h44, 1, 0, 0);
        add(1, 0, 32'hDEADBEEF, 0, 8'h44, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h33, 1, 0, 0);
        add(0, 0, 32'h0,        0, 8'h33, 1, 0, 0);
        add(0, 0, 32'h0,        0, 8'h33, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h22, 1, 0, 0);
        add(0, 0, 32'h0,        0, 8'h22, 1, 0, 0);
        add(0, 0, 32'h0,        0, 8'h22, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h11, 1, 1, 0);
        add(0, 0, 32'h0,        0, 8'h11, 1, 1, 0);
        add(0, 0, 32'h0,        0, 8'h11, 1, 1, 0);
        add(0, 1, 32'h0,        1, IDLEV, 0, 0, 1);
        add(0, 0, 32'h0,        1, IDLEV, 0, 0, 0);
        // --- back-to-back frames
        add(1, 0, 32'h44332211, 1, 8'h44, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h33, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h22, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'h11, 1, 1, 0);
        add(1, 1, 32'hAABBCCDD, 1, 8'hAA, 1, 0, 1);
        add(0, 1, 32'h0,        0, 8'hBB, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'hCC, 1, 0, 0);
        add(0, 1, 32'h0,        0, 8'hDD, 1, 1, 0);
        add(0, 1, 32'h0,        1, IDLEV, 0, 0, 1);
        add(0, 1, 32'h0,        1, IDLEV, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // --- asynchronous reset mid-frame
        cyc(1, 0, 32'h44332211);
        cyc(0, 1, 32'h0);
        chk("mid.out_before", 32'(out_w), 32'h33);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid.out",        32'(out_w),      32'(IDLEV));
        chk("mid.out_valid",  32'(out_valid),  0);
        chk("mid.out_last",   32'(out_last),   0);
        chk("mid.done",       32'(done),       0);
        chk("mid.load_ready", 32'(load_ready), 0);
        @(posedge clk); #1;
        chk("mid.done_held",  32'(done),       0);
        chk("mid.out_held",   32'(out_w),      32'(IDLEV));
        reset = 1'b0;
        shift_en = 1'b0;
        #1;
        chk("mid.ready_after", 32'(load_ready), 1);
        @(posedge clk); #1;
        chk("mid.done_after", 32'(done), 0);
        cyc(1, 0, 32'h5A6B7C8D);
        chk("mid.reload_out",   32'(out_w),     32'h5A);
        chk("mid.reload_valid", 32'(out_valid), 1);
        cyc(0, 1, 32'h0);
        chk("mid.reload_2nd",   32'(out_w),     32'h6B);
        cyc(0, 1, 32'h0);
        cyc(0, 1, 32'h0);
        chk("mid.reload_last",  32'(out_last),  1);
        cyc(0, 1, 32'h0);
        chk("mid.reload_done",  32'(done),      1);

        // --- loopback: SIPO delay line (newest at index 0) re-serialised
        sipo = '0;
        for (int k = 0; k < NW; k++) begin
            stream[k] = DW'($urandom_range(0, 255));
            sipo = {sipo[NW-2:0], stream[k]};
        end
        cyc(1, 0, sipo);
        for (int k = 0; k < NW; k++) begin
            chk($sformatf("loop.word%0d", k), 32'(out_w), 32'(stream[k]));
            chk($sformatf("loop.last%0d", k), 32'(out_last), (k == NW - 1) ? 32'd1 : 32'd0);
            cyc(0, 1, 32'h0);
        end
        chk("loop.done",  32'(done),      1);
        chk("loop.valid", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
